data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single data port of the integrated instruction/data memory between two requesters: m0 (CPU load/store unit) and m1 (program loader / DMA).
- Grants by 2-way round-robin and holds the memory strobes for a fixed number of cycles.
- Returns read data with a one-cycle ack.
- Blocks illegal accesses: misaligned, out of range, or a CPU write into instruction space. These are answered with an error ack and never reach memory.

Parameters:
- MEM_SIZE, 32'h0000_4000, byte size of memory; valid addresses are 0 to MEM_SIZE-4.
- IMEM_BASE, 32'h0000_3000, first byte of instruction space; m0 writes at or above it are errors.
- RD_CYCLES, 1, cycles mem_read is held before rdata capture (>=1).
- WR_CYCLES, 2, cycles mem_write is held (>=1).

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- m0_req, input, 1, m0 request; held until m0_ack.
- m0_we, input, 1, 1 = write, 0 = read.
- m0_addr, input, 32, byte address.
- m0_wdata, input, 32, write data.
- m0_ack, output, 1, one-cycle completion pulse.
- m0_err, output, 1, valid with m0_ack; 1 = rejected.
- m0_rdata, output, 32, read data; valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0, for requester m1.
- mem_addr, output, 32, to memory data_addr.
- mem_wdata, output, 32, to memory data_in.
- mem_read, output, 1, to memory mem_read.
- mem_write, output, 1, to memory mem_write.
- mem_rdata, input, 32, from memory data_out (combinational).

Behaviour:
- All outputs are registered.
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all acks, errs and mem strobes = 0.
  - mem_addr, mem_wdata and all rdata = 0.
  - Priority pointer favours m0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If neither req is set, stay in IDLE.
  - Otherwise grant one requester: the only requester, or the prioritised one if both request.
  - Latch addr, we, wdata and the grant id.
  - Check the latched request. It is illegal if any of these hold:
    - addr[1:0] != 0;
    - addr > MEM_SIZE-4;
    - m0 with we=1 and addr >= IMEM_BASE.
  - Illegal: go to DONE with err=1 and rdata=0; memory is untouched.
  - Legal: go to ACCESS, load the cycle counter with (we ? WR_CYCLES : RD_CYCLES) - 1, and drive mem_addr/mem_wdata plus mem_write or mem_read.
- ACCESS:
  - Hold the mem_* outputs stable.
  - Counter != 0: decrement.
  - Counter == 0: on a read, capture mem_rdata into the granted master's rdata; drop both strobes; go to DONE.
- DONE:
  - Granted ack = 1 for exactly this cycle; err as determined in IDLE.
  - Priority pointer moves to the non-granted master.
  - Next state is IDLE.
- Latency (req seen in IDLE to ack high):
  - Legal read: RD_CYCLES+1 cycles.
  - Legal write: WR_CYCLES+1 cycles.
  - Error: 1 cycle.
- Throughput: at most one access in flight. Minimum spacing between grants is ACCESS length + 2 cycles.
- Handshake rules for requesters:
  - Keep req, we, addr and wdata stable from assertion until ack.
  - Deassert req, or present a new request, in the cycle after ack.
  - Arbitration only samples req in IDLE, so no stale re-grant is possible.
- Simultaneous requests: the loser stays pending and is granted on the next IDLE. Under continuous contention the grants alternate m0, m1, m0, ...
- The non-granted master's ack, err and rdata stay 0 / unchanged.
- Reset mid-ACCESS:
  - Strobes drop immediately (asynchronously); no ack is issued.
  - A partially performed write is not rolled back.
  - Requesters must reissue after reset.
- Boundaries:
  - addr = MEM_SIZE-4 is legal.
  - addr = MEM_SIZE is an error.
  - addr = 32'hFFFF_FFFC is an error; no wrap-around.
  - m1 may write anywhere in range (program load).
  - Reads of instruction space are legal for both masters.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - address-map constants MEM_SIZE and IMEM_BASE, also used by the memory and the loader.
- One sub-module: rr_arb2.
  - Inputs req[1:0], advance. Output one-hot grant[1:0]. Holds the internal priority bit.
  - The FSM pulses advance in DONE.

Test Plan:
- Single m0 read, addr 0x0010, memory word 0xDEADBEEF, RD_CYCLES=1 -> mem_read high for 1 cycle; m0_ack 2 cycles after req; m0_rdata=0xDEADBEEF; m0_err=0.
- m1 write of 0x12345678 to 0x3000, WR_CYCLES=2 -> mem_write high for exactly 2 cycles with mem_addr=0x3000; m1_ack, err=0; a subsequent m0 read of 0x3000 returns 0x12345678.
- m0 write to 0x3004 -> m0_ack with m0_err=1 one cycle after req; mem_write never asserted; memory word unchanged.
- Misaligned m1 read 0x0002, then m0 read of 0x4000 -> both get err=1 and rdata=0; no mem_read pulse.
- m0 and m1 requesting together continuously, 4 transactions -> grant order m0, m1, m0, m1; each ack pulses for 1 cycle; the other master's ack stays 0.
- rst_n asserted during the second write cycle -> mem_write and acks drop immediately; state is IDLE after release; the first post-reset simultaneous request goes to m0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared data-memory controller definitions: FSM encoding, address map and
// the access legality rule used by the arbiter.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [31:0] MEM_SIZE  = 32'h0000_4000;
   localparam logic [31:0] IMEM_BASE = 32'h0000_3000;

   localparam int CNT_W = 8;
   typedef logic [CNT_W-1:0] cnt_t;

   // A request never reaches memory if it is misaligned, past the last word,
   // or a CPU store into instruction space.
   function automatic logic access_illegal(input logic [31:0] addr,
                                           input logic        we,
                                           input logic        from_cpu);
      logic misaligned;
      logic out_of_range;
      logic imem_write;
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = (addr > (MEM_SIZE - 32'd4));
      imem_write   = from_cpu && we && (addr >= IMEM_BASE);
      return misaligned || out_of_range || imem_write;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory data port.
interface data_mem_arbiter_if;

   logic        m0_req;
   logic        m0_we;
   logic [31:0] m0_addr;
   logic [31:0] m0_wdata;
   logic        m0_ack;
   logic        m0_err;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_ack;
   logic        m1_err;
   logic [31:0] m1_rdata;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_rdata,
      output m0_ack, m0_err, m0_rdata,
      output m1_ack, m1_err, m1_rdata,
      output mem_addr, mem_wdata, mem_read, mem_write
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_rdata,
      input  m0_ack, m0_err, m0_rdata,
      input  m1_ack, m1_err, m1_rdata,
      input  mem_addr, mem_wdata, mem_read, mem_write
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority bit moves to the loser on advance.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic prio_r;  // 0 favours requester 0

   // One-hot grant from the current requests and priority bit
   always_comb begin
      grant = 2'b00;
      if (req == 2'b11) begin
         grant = prio_r ? 2'b10 : 2'b01;
      end else begin
         grant = req;
      end
   end

   // Priority pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_r <= 1'b0;
      end else if (advance && (grant != 2'b00)) begin
         prio_r <= grant[0];
      end else begin
         prio_r <= prio_r;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the memory data port between the CPU (m0) and the loader (m1), with
// fixed-length strobes, registered acks and rejection of illegal accesses.
module data_mem_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int RD_CYCLES = 1,
   parameter int WR_CYCLES = 2
) (
   input logic               clk,
   input logic               rst_n,
   data_mem_arbiter_if.slave bus
);

   localparam cnt_t RD_LOAD = cnt_t'(RD_CYCLES - 1);
   localparam cnt_t WR_LOAD = cnt_t'(WR_CYCLES - 1);

   state_t      state_r, state_n;
   logic        gnt_r, gnt_n;
   logic        we_r, we_n;
   cnt_t        cnt_r, cnt_n;
   logic [31:0] mem_addr_r, mem_addr_n;
   logic [31:0] mem_wdata_r, mem_wdata_n;
   logic        mem_read_r, mem_read_n;
   logic        mem_write_r, mem_write_n;
   logic        m0_ack_r, m0_ack_n;
   logic        m0_err_r, m0_err_n;
   logic [31:0] m0_rdata_r, m0_rdata_n;
   logic        m1_ack_r, m1_ack_n;
   logic        m1_err_r, m1_err_n;
   logic [31:0] m1_rdata_r, m1_rdata_n;

   logic [1:0]  arb_req_s;
   logic [1:0]  grant_s;
   logic        advance_s;
   logic        sel_m1_s;
   logic        req_we_s;
   logic [31:0] req_addr_s;
   logic [31:0] req_wdata_s;
   logic        illegal_s;

   // Outside IDLE only the owner is shown to the arbiter, so the pointer
   // update in DONE always sees the grant that was actually served.
   always_comb begin
      arb_req_s = 2'b00;
      advance_s = (state_r == DONE);
      if (state_r == IDLE) begin
         arb_req_s = {bus.m1_req, bus.m0_req};
      end else begin
         arb_req_s = gnt_r ? 2'b10 : 2'b01;
      end
   end

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (arb_req_s),
      .advance (advance_s),
      .grant   (grant_s)
   );

   // Selected request and its legality
   always_comb begin
      sel_m1_s = grant_s[1];
      if (sel_m1_s) begin
         req_we_s    = bus.m1_we;
         req_addr_s  = bus.m1_addr;
         req_wdata_s = bus.m1_wdata;
      end else begin
         req_we_s    = bus.m0_we;
         req_addr_s  = bus.m0_addr;
         req_wdata_s = bus.m0_wdata;
      end
      illegal_s = access_illegal(req_addr_s, req_we_s, !sel_m1_s);
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state_r;
      gnt_n       = gnt_r;
      we_n        = we_r;
      cnt_n       = cnt_r;
      mem_addr_n  = mem_addr_r;
      mem_wdata_n = mem_wdata_r;
      mem_read_n  = mem_read_r;
      mem_write_n = mem_write_r;
      m0_ack_n    = m0_ack_r;
      m0_err_n    = m0_err_r;
      m0_rdata_n  = m0_rdata_r;
      m1_ack_n    = m1_ack_r;
      m1_err_n    = m1_err_r;
      m1_rdata_n  = m1_rdata_r;

      case (state_r)
         IDLE: begin
            if (grant_s != 2'b00) begin
               gnt_n = sel_m1_s;
               we_n  = req_we_s;
               if (illegal_s) begin
                  state_n = DONE;
                  if (sel_m1_s) begin
                     m1_ack_n   = 1'b1;
                     m1_err_n   = 1'b1;
                     m1_rdata_n = 32'd0;
                  end else begin
                     m0_ack_n   = 1'b1;
                     m0_err_n   = 1'b1;
                     m0_rdata_n = 32'd0;
                  end
               end else begin
                  state_n     = ACCESS;
                  cnt_n       = req_we_s ? WR_LOAD : RD_LOAD;
                  mem_addr_n  = req_addr_s;
                  mem_wdata_n = req_wdata_s;
                  mem_write_n = req_we_s;
                  mem_read_n  = !req_we_s;
               end
            end else begin
               state_n = IDLE;
            end
         end

         ACCESS: begin
            if (cnt_r != cnt_t'(0)) begin
               cnt_n = cnt_r - cnt_t'(1);
            end else begin
               state_n     = DONE;
               mem_read_n  = 1'b0;
               mem_write_n = 1'b0;
               if (gnt_r) begin
                  m1_ack_n = 1'b1;
                  m1_err_n = 1'b0;
                  if (!we_r) begin
                     m1_rdata_n = bus.mem_rdata;
                  end else begin
                     m1_rdata_n = m1_rdata_r;
                  end
               end else begin
                  m0_ack_n = 1'b1;
                  m0_err_n = 1'b0;
                  if (!we_r) begin
                     m0_rdata_n = bus.mem_rdata;
                  end else begin
                     m0_rdata_n = m0_rdata_r;
                  end
               end
            end
         end

         DONE: begin
            state_n  = IDLE;
            m0_ack_n = 1'b0;
            m0_err_n = 1'b0;
            m1_ack_n = 1'b0;
            m1_err_n = 1'b0;
         end

         default: begin
            state_n     = IDLE;
            mem_read_n  = 1'b0;
            mem_write_n = 1'b0;
            m0_ack_n    = 1'b0;
            m1_ack_n    = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         gnt_r       <= 1'b0;
         we_r        <= 1'b0;
         cnt_r       <= cnt_t'(0);
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         m0_ack_r    <= 1'b0;
         m0_err_r    <= 1'b0;
         m0_rdata_r  <= 32'd0;
         m1_ack_r    <= 1'b0;
         m1_err_r    <= 1'b0;
         m1_rdata_r  <= 32'd0;
      end else begin
         state_r     <= state_n;
         gnt_r       <= gnt_n;
         we_r        <= we_n;
         cnt_r       <= cnt_n;
         mem_addr_r  <= mem_addr_n;
         mem_wdata_r <= mem_wdata_n;
         mem_read_r  <= mem_read_n;
         mem_write_r <= mem_write_n;
         m0_ack_r    <= m0_ack_n;
         m0_err_r    <= m0_err_n;
         m0_rdata_r  <= m0_rdata_n;
         m1_ack_r    <= m1_ack_n;
         m1_err_r    <= m1_err_n;
         m1_rdata_r  <= m1_rdata_n;
      end
   end

   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_read  = mem_read_r;
   assign bus.mem_write = mem_write_r;
   assign bus.m0_ack    = m0_ack_r;
   assign bus.m0_err    = m0_err_r;
   assign bus.m0_rdata  = m0_rdata_r;
   assign bus.m1_ack    = m1_ack_r;
   assign bus.m1_err    = m1_err_r;
   assign bus.m1_rdata  = m1_rdata_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter with a transaction-level reference
// model (word-array memory, legality rules, round-robin order, latencies).
module tb_data_mem_arbiter;
   import mem_ctrl_pkg::*;

   localparam int RD = 1;
   localparam int WR = 2;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   data_mem_arbiter_if bus();

   data_mem_arbiter #(.RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory behind the data port: untouched words read a fixed pattern
   logic [31:0] mem     [0:4095];
   bit          wr_mask [0:4095];

   function automatic logic [31:0] init_word(input logic [11:0] idx);
      if (idx == 12'd4) return 32'hDEAD_BEEF;
      return 32'h5A00_0000 ^ ({20'd0, idx} * 32'h9E37_79B1);
   endfunction

   assign bus.mem_rdata = wr_mask[bus.mem_addr[13:2]] ? mem[bus.mem_addr[13:2]]
                                                      : init_word(bus.mem_addr[13:2]);

   always @(posedge clk) begin
      if (bus.mem_write) begin
         mem[bus.mem_addr[13:2]]     <= bus.mem_wdata;
         wr_mask[bus.mem_addr[13:2]] <= 1'b1;
      end
   end

   // Reference model state
   logic [31:0] ref_mem    [0:4095];
   logic [31:0] last_rdata [0:1];
   logic        prio_m;
   logic        single_mode;
   txn_t        q0[$];
   txn_t        q1[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic exp_illegal(input int m, input txn_t t);
      logic [32:0] end_addr;
      end_addr = {1'b0, t.addr} + 33'd4;
      return (t.addr % 32'd4 != 32'd0) || (end_addr > {1'b0, MEM_SIZE}) ||
             (m == 0 && t.we && t.addr >= IMEM_BASE);
   endfunction

   function automatic int exp_latency(input int m, input txn_t t);
      if (exp_illegal(m, t)) return 1;
      return t.we ? WR + 1 : RD + 1;
   endfunction

   function automatic txn_t rand_txn();
      txn_t        t;
      int unsigned kind;
      int unsigned sel;
      t.we    = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      kind    = $urandom_range(0, 5);
      sel     = $urandom_range(0, 2);
      case (kind)
         0, 1:    t.addr = {18'd0, 12'($urandom_range(0, 3071)), 2'b00};
         2:       t.addr = 32'h0000_3000 + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
         3: begin
            t.addr      = {18'd0, 14'($urandom)};
            t.addr[1:0] = 2'($urandom_range(1, 3));
         end
         4:       t.addr = 32'h0000_4000 + ($urandom & 32'h0FFF_FFFC);
         default: t.addr = (sel == 0) ? 32'h0000_3FFC : (sel == 1) ? 32'h0000_4000 : 32'hFFFF_FFFC;
      endcase
      return t;
   endfunction

   function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      txn_t t;
      t.we = we; t.addr = addr; t.wdata = wdata;
      return t;
   endfunction

   task automatic present(input int m, input txn_t t);
      if (m == 0) begin
         bus.m0_req = 1'b1; bus.m0_we = t.we; bus.m0_addr = t.addr; bus.m0_wdata = t.wdata;
      end else begin
         bus.m1_req = 1'b1; bus.m1_we = t.we; bus.m1_addr = t.addr; bus.m1_wdata = t.wdata;
      end
   endtask

   task automatic drop_req(input int m);
      if (m == 0) bus.m0_req = 1'b0;
      else        bus.m1_req = 1'b0;
   endtask

   task automatic finish_txn(input int m, input txn_t t, input int st, input bit other_pending,
                             input int rd_cnt, input int wr_cnt, input logic [31:0] saddr);
      logic        ill;
      logic [31:0] exp_rd;
      ill = exp_illegal(m, t);
      if (other_pending) check("grant_order", 32'(m), 32'(prio_m));
      prio_m = (m == 0);
      check(m == 0 ? "m0_err" : "m1_err",
            m == 0 ? 32'(bus.m0_err) : 32'(bus.m1_err), 32'(ill));
      if (ill)       exp_rd = 32'd0;
      else if (t.we) exp_rd = last_rdata[m];
      else           exp_rd = ref_mem[t.addr[13:2]];
      check(m == 0 ? "m0_rdata" : "m1_rdata", m == 0 ? bus.m0_rdata : bus.m1_rdata, exp_rd);
      last_rdata[m] = exp_rd;
      check("other_rdata_hold", m == 0 ? bus.m1_rdata : bus.m0_rdata, last_rdata[1-m]);
      if (!ill && t.we) ref_mem[t.addr[13:2]] = t.wdata;
      check("rd_cycles", 32'(rd_cnt), (!ill && !t.we) ? 32'(RD) : 32'd0);
      check("wr_cycles", 32'(wr_cnt), (!ill && t.we) ? 32'(WR) : 32'd0);
      if (!ill) check("strobe_addr", saddr, t.addr);
      if (single_mode) check("latency", 32'(cyc - st), 32'(exp_latency(m, t)));
   endtask

   // Drives both request queues until empty; entered and left at posedge+1
   task automatic run_batch();
      txn_t        cur      [0:1];
      int          start    [0:1];
      bit          act      [0:1];
      bit          done     [0:1];
      bit          prev_ack [0:1];
      logic        ack      [0:1];
      int          rd_cnt, wr_cnt, budget;
      logic [31:0] saddr;
      rd_cnt = 0; wr_cnt = 0; budget = 0; saddr = 32'd0;
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; done[i] = 1'b0; prev_ack[i] = 1'b0; start[i] = 0; cur[i] = '0;
      end
      if (q0.size() > 0) begin cur[0] = q0.pop_front(); present(0, cur[0]); start[0] = cyc; act[0] = 1'b1; end
      if (q1.size() > 0) begin cur[1] = q1.pop_front(); present(1, cur[1]); start[1] = cyc; act[1] = 1'b1; end
      while ((act[0] || act[1]) && budget < 400) begin
         @(negedge clk);
         budget++;
         if (bus.mem_read)  begin rd_cnt++; saddr = bus.mem_addr; end
         if (bus.mem_write) begin wr_cnt++; saddr = bus.mem_addr; end
         ack[0] = bus.m0_ack;
         ack[1] = bus.m1_ack;
         if (prev_ack[0]) check("m0_ack_pulse", 32'(ack[0]), 32'd0);
         if (prev_ack[1]) check("m1_ack_pulse", 32'(ack[1]), 32'd0);
         if (ack[0] || ack[1]) check("ack_onehot", 32'(ack[0]) + 32'(ack[1]), 32'd1);
         for (int k = 0; k < 2; k++) begin
            if (ack[k]) begin
               finish_txn(k, cur[k], start[k], act[1-k], rd_cnt, wr_cnt, saddr);
               rd_cnt = 0; wr_cnt = 0; done[k] = 1'b1;
            end
         end
         prev_ack[0] = ack[0];
         prev_ack[1] = ack[1];
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (done[k]) begin
               done[k] = 1'b0;
               if (k == 0 && q0.size() > 0) begin
                  cur[0] = q0.pop_front(); present(0, cur[0]); start[0] = cyc;
               end else if (k == 1 && q1.size() > 0) begin
                  cur[1] = q1.pop_front(); present(1, cur[1]); start[1] = cyc;
               end else begin
                  drop_req(k); act[k] = 1'b0;
               end
            end
         end
      end
      check("batch_done", {30'd0, act[1], act[0]}, 32'd0);
      drop_req(0); drop_req(1);
      q0.delete(); q1.delete();
      @(negedge clk);
      check("acks_quiet", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do1(input int m, input txn_t t);
      single_mode = 1'b1;
      if (m == 0) q0.push_back(t);
      else        q1.push_back(t);
      run_batch();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          diffs;
      logic [31:0] eff;
      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 32'd0; bus.m0_wdata = 32'd0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = 32'd0; bus.m1_wdata = 32'd0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(12'(i));
      last_rdata[0] = 32'd0; last_rdata[1] = 32'd0;
      prio_m = 1'b0; single_mode = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", {26'd0, bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err,
                         bus.mem_read, bus.mem_write}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_rdata", bus.m0_rdata | bus.m1_rdata, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed transactions from the test plan and address boundaries
      do1(0, mk(1'b0, 32'h0000_0010, 32'd0));
      check("plan_m0_read", bus.m0_rdata, 32'hDEAD_BEEF);
      do1(1, mk(1'b1, 32'h0000_3000, 32'h1234_5678));
      do1(0, mk(1'b0, 32'h0000_3000, 32'd0));
      check("plan_imem_read", bus.m0_rdata, 32'h1234_5678);
      do1(0, mk(1'b1, 32'h0000_3004, 32'hCAFE_F00D));
      do1(1, mk(1'b0, 32'h0000_0002, 32'd0));
      do1(0, mk(1'b0, 32'h0000_4000, 32'd0));
      do1(1, mk(1'b0, 32'h0000_3FFC, 32'd0));
      do1(0, mk(1'b0, 32'hFFFF_FFFC, 32'd0));
      do1(1, mk(1'b1, 32'h0000_3FFC, 32'hA1B2_C3D4));
      do1(0, mk(1'b0, 32'h0000_3FFC, 32'd0));
      do1(0, mk(1'b1, 32'h0000_2FFC, 32'h55AA_55AA));

      for (int i = 0; i < 30; i++) do1(int'($urandom_range(0, 1)), rand_txn());

      // Continuous contention: reads, then random mixes
      single_mode = 1'b0;
      q0.push_back(mk(1'b0, 32'h0000_0100, 32'd0));
      q0.push_back(mk(1'b0, 32'h0000_0108, 32'd0));
      q1.push_back(mk(1'b0, 32'h0000_0104, 32'd0));
      q1.push_back(mk(1'b0, 32'h0000_010C, 32'd0));
      run_batch();
      for (int r = 0; r < 3; r++) begin
         single_mode = 1'b0;
         for (int i = 0; i < 5; i++) begin
            q0.push_back(rand_txn());
            q1.push_back(rand_txn());
         end
         run_batch();
      end

      // Reset during the second write cycle
      present(1, mk(1'b1, 32'h0000_2000, 32'h0BAD_F00D));
      @(posedge clk);
      @(negedge clk);
      check("pre_rst_write", 32'(bus.mem_write), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_async_ctrl", {28'd0, bus.mem_write, bus.mem_read, bus.m0_ack, bus.m1_ack}, 32'd0);
      check("rst_async_rdata", bus.m0_rdata | bus.m1_rdata, 32'd0);
      drop_req(1);
      ref_mem[32'h0000_2000 >> 2] = 32'h0BAD_F00D;
      prio_m = 1'b0;
      last_rdata[0] = 32'd0; last_rdata[1] = 32'd0;
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      single_mode = 1'b0;
      q0.push_back(mk(1'b0, 32'h0000_2000, 32'd0));
      q1.push_back(mk(1'b0, 32'h0000_0010, 32'd0));
      run_batch();
      check("post_rst_partial_write", bus.m0_rdata, 32'h0BAD_F00D);

      diffs = 0;
      for (int i = 0; i < 4096; i++) begin
         eff = wr_mask[i] ? mem[i] : init_word(12'(i));
         if (eff !== ref_mem[i]) diffs++;
      end
      check("mem_image", 32'(diffs), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
